// File: rtl/gci_std_display_pkg.sv
// Shared definitions for the display command sequencer: command address map,
// sequencer states, the queued command record and RGB888 field positions.
package gci_std_display_pkg;

    localparam logic [30:0] CMD_CLEAR_ADDR = 31'h0000_3000;
    localparam logic [30:0] CMD_PIXEL_BASE = 31'h0000_3100;

    localparam int RGB_R_LSB = 16;
    localparam int RGB_G_LSB = 8;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WORK      = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_END       = 3'd5
    } state_e;

    // One queued bus command; rd duplicates addr[31] so the FIFO word is 65 bits.
    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic [7:0] rgb_field(input logic [23:0] rgb, input int lsb);
        return rgb[lsb +: 8];
    endfunction

endpackage

// File: rtl/gci_std_display_cmd_sequencer_if.sv
// Bus-side and VRAM-side handshake bundle of the display command sequencer.
interface gci_std_display_cmd_sequencer_if #(
    parameter int P_MEM_ADDR_N = 23
);
    logic                    iBUSMOD_REQ;
    logic [31:0]             iBUSMOD_ADDR;
    logic [31:0]             iBUSMOD_DATA;
    logic                    oBUSMOD_WAIT;
    logic                    oBUS_VALID;
    logic [31:0]             oBUS_DATA;
    logic                    oIF_REQ;
    logic                    iIF_ACK;
    logic                    oIF_FINISH;
    logic                    iIF_BREAK;
    logic                    iIF_BUSY;
    logic                    oIF_ENA;
    logic                    oIF_RW;
    logic [P_MEM_ADDR_N-1:0] oIF_ADDR;
    logic [7:0]              oIF_R;
    logic [7:0]              oIF_G;
    logic [7:0]              oIF_B;
    logic                    iIF_VALID;
    logic [31:0]             iIF_DATA;

    modport master (
        output iBUSMOD_REQ, iBUSMOD_ADDR, iBUSMOD_DATA,
        input  oBUSMOD_WAIT, oBUS_VALID, oBUS_DATA,
        input  oIF_REQ, oIF_FINISH, oIF_ENA, oIF_RW, oIF_ADDR, oIF_R, oIF_G, oIF_B,
        output iIF_ACK, iIF_BREAK, iIF_BUSY, iIF_VALID, iIF_DATA
    );

    modport slave (
        input  iBUSMOD_REQ, iBUSMOD_ADDR, iBUSMOD_DATA,
        output oBUSMOD_WAIT, oBUS_VALID, oBUS_DATA,
        output oIF_REQ, oIF_FINISH, oIF_ENA, oIF_RW, oIF_ADDR, oIF_R, oIF_G, oIF_B,
        input  iIF_ACK, iIF_BREAK, iIF_BUSY, iIF_VALID, iIF_DATA
    );

endinterface

// File: rtl/gci_std_display_sync_fifo.sv
// Single-clock command FIFO with a registered full flag and combinational head.
module gci_std_display_sync_fifo #(
    parameter int P_WIDTH = 65,
    parameter int P_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [P_WIDTH-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(P_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(P_DEPTH);

    logic [P_WIDTH-1:0] mem_r [P_DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic [AW:0]        count_s;
    logic               full_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & (count_r != '0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
            full_r  <= (count_s == CNT_DEPTH);
        end
    end

    // Storage array; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/gci_std_display_cmd_sequencer.sv
// Queues bus commands and replays them as VRAM pixel writes, reads and
// full-screen clears, yielding the VRAM port whenever the arbiter asks.
module gci_std_display_cmd_sequencer
    import gci_std_display_pkg::*;
#(
    parameter int P_AREA_H     = 640,
    parameter int P_AREA_V     = 480,
    parameter int P_MEM_ADDR_N = 23,
    parameter int P_FIFO_DEPTH = 16
) (
    input  logic iCLOCK,
    input  logic iRESET_SYNC,
    gci_std_display_cmd_sequencer_if.slave bus
);

    localparam int PIXELS = P_AREA_H * P_AREA_V;
    localparam logic [30:0]             PIX_END  = CMD_PIXEL_BASE + 31'(PIXELS);
    localparam logic [P_MEM_ADDR_N-1:0] LAST_IDX = P_MEM_ADDR_N'(PIXELS - 1);
    localparam logic [P_MEM_ADDR_N-1:0] IDX_ONE  = P_MEM_ADDR_N'(1);

    if (P_MEM_ADDR_N < $clog2(PIXELS) || P_MEM_ADDR_N > 31) begin : g_bad_addr_width
        $fatal(1, "P_MEM_ADDR_N cannot address every pixel of the display area");
    end
    if (P_FIFO_DEPTH < 2 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "P_FIFO_DEPTH must be a power of two and at least 2");
    end

    state_e                  state_r, state_s;
    logic [P_MEM_ADDR_N-1:0] clr_idx_r, clr_idx_s;
    logic [23:0]             clr_color_r, clr_color_s;
    logic                    clr_pend_r, clr_pend_s;
    logic                    bus_valid_r, bus_valid_s;
    logic [31:0]             bus_data_r, bus_data_s;

    logic                    fifo_pop_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    cmd_t                    push_cmd_s;
    cmd_t                    head_s;

    logic                    if_req_s;
    logic                    if_finish_s;
    logic                    if_ena_s;
    logic                    if_rw_s;
    logic [P_MEM_ADDR_N-1:0] if_addr_s;
    logic [23:0]             if_rgb_s;

    logic [30:0]             head_addr_s;
    logic [30:0]             pix_off_s;
    logic [P_MEM_ADDR_N-1:0] pix_idx_s;
    logic                    is_clear_s;
    logic                    is_pixel_s;
    logic                    unused_bits;

    assign push_cmd_s = '{rd: bus.iBUSMOD_ADDR[31], addr: bus.iBUSMOD_ADDR, data: bus.iBUSMOD_DATA};

    gci_std_display_sync_fifo #(
        .P_WIDTH (CMD_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk       (iCLOCK),
        .rst       (iRESET_SYNC),
        .push      (bus.iBUSMOD_REQ),
        .push_data (push_cmd_s),
        .pop       (fifo_pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign head_addr_s = head_s.addr[30:0];
    assign pix_off_s   = head_addr_s - CMD_PIXEL_BASE;
    assign pix_idx_s   = pix_off_s[P_MEM_ADDR_N-1:0];
    assign is_clear_s  = (head_addr_s == CMD_CLEAR_ADDR);
    assign is_pixel_s  = (head_addr_s >= CMD_PIXEL_BASE) && (head_addr_s < PIX_END);
    assign unused_bits = ^{head_s.addr[31], head_s.data[31:24], pix_off_s};

    // Next-state and VRAM strobe decode; strobes are combinational so BUSY gates them in-cycle.
    always_comb begin
        state_s     = state_r;
        clr_idx_s   = clr_idx_r;
        clr_color_s = clr_color_r;
        clr_pend_s  = clr_pend_r;
        bus_valid_s = 1'b0;
        bus_data_s  = bus_data_r;
        fifo_pop_s  = 1'b0;
        if_req_s    = 1'b0;
        if_finish_s = 1'b0;
        if_ena_s    = 1'b0;
        if_rw_s     = 1'b0;
        if_addr_s   = '0;
        if_rgb_s    = 24'h00_0000;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s || clr_pend_r) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if_req_s = 1'b1;
                if (bus.iIF_ACK) begin
                    state_s = ST_WORK;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WORK: begin
                if (bus.iIF_BREAK || (fifo_empty_s && !clr_pend_r)) begin
                    state_s = ST_END;
                end else if (clr_pend_r) begin
                    state_s = ST_CLEAR;
                end else if (bus.iIF_BUSY) begin
                    state_s = ST_WORK;
                end else begin
                    fifo_pop_s = 1'b1;
                    if (is_clear_s) begin
                        clr_color_s = head_s.data[23:0];
                        clr_idx_s   = '0;
                        clr_pend_s  = 1'b1;
                        state_s     = ST_CLEAR;
                    end else if (is_pixel_s) begin
                        if_ena_s  = 1'b1;
                        if_addr_s = pix_idx_s;
                        if (head_s.rd) begin
                            if_rw_s = 1'b0;
                            state_s = ST_READ_WAIT;
                        end else begin
                            if_rw_s  = 1'b1;
                            if_rgb_s = head_s.data[23:0];
                            state_s  = ST_WORK;
                        end
                    end else begin
                        state_s = ST_WORK;
                    end
                end
            end
            ST_CLEAR: begin
                if (!bus.iIF_BUSY) begin
                    if_ena_s  = 1'b1;
                    if_rw_s   = 1'b1;
                    if_addr_s = clr_idx_r;
                    if_rgb_s  = clr_color_r;
                end else begin
                    if_ena_s = 1'b0;
                end
                if (!bus.iIF_BUSY && clr_idx_r == LAST_IDX) begin
                    clr_pend_s = 1'b0;
                    state_s    = ST_WORK;
                end else begin
                    if (!bus.iIF_BUSY) begin
                        clr_idx_s = clr_idx_r + IDX_ONE;
                    end else begin
                        clr_idx_s = clr_idx_r;
                    end
                    // A break leaves clr_pend set so the next grant resumes at clr_idx.
                    if (bus.iIF_BREAK) begin
                        state_s = ST_END;
                    end else begin
                        state_s = ST_CLEAR;
                    end
                end
            end
            ST_READ_WAIT: begin
                if (bus.iIF_VALID) begin
                    bus_valid_s = 1'b1;
                    bus_data_s  = bus.iIF_DATA;
                    state_s     = ST_WORK;
                end else begin
                    state_s = ST_READ_WAIT;
                end
            end
            ST_END: begin
                if_finish_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, clear progress and the registered read-return pulse.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_r     <= ST_IDLE;
            clr_idx_r   <= '0;
            clr_color_r <= 24'h00_0000;
            clr_pend_r  <= 1'b0;
            bus_valid_r <= 1'b0;
            bus_data_r  <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            clr_idx_r   <= clr_idx_s;
            clr_color_r <= clr_color_s;
            clr_pend_r  <= clr_pend_s;
            bus_valid_r <= bus_valid_s;
            bus_data_r  <= bus_data_s;
        end
    end

    // Holding reset forces every VRAM-side output low, so an abandoned access never finishes.
    assign bus.oBUSMOD_WAIT = fifo_full_s;
    assign bus.oBUS_VALID   = bus_valid_r;
    assign bus.oBUS_DATA    = bus_data_r;
    assign bus.oIF_REQ      = if_req_s & ~iRESET_SYNC;
    assign bus.oIF_FINISH   = if_finish_s & ~iRESET_SYNC;
    assign bus.oIF_ENA      = if_ena_s & ~iRESET_SYNC;
    assign bus.oIF_RW       = if_rw_s & ~iRESET_SYNC;
    assign bus.oIF_ADDR     = iRESET_SYNC ? '0 : if_addr_s;
    assign bus.oIF_R        = iRESET_SYNC ? 8'h00 : rgb_field(if_rgb_s, RGB_R_LSB);
    assign bus.oIF_G        = iRESET_SYNC ? 8'h00 : rgb_field(if_rgb_s, RGB_G_LSB);
    assign bus.oIF_B        = iRESET_SYNC ? 8'h00 : rgb_field(if_rgb_s, RGB_B_LSB);

endmodule

// File: tb/tb_gci_std_display_cmd_sequencer.sv
// Directed bench for the display command sequencer on a 4x2 display with a 16-entry FIFO.
module tb_gci_std_display_cmd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    gci_std_display_cmd_sequencer_if #(.P_MEM_ADDR_N(23)) bus ();

    gci_std_display_cmd_sequencer #(
        .P_AREA_H     (4),
        .P_AREA_V     (2),
        .P_MEM_ADDR_N (23),
        .P_FIFO_DEPTH (16)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          ena_cnt = 0;
    int          ena_busy_cnt = 0;
    int          fin_cnt = 0;
    int          val_cnt = 0;
    int          bad_color_cnt = 0;
    int          wr_cnt [8] = '{default: 0};
    logic [22:0] last_addr = '0;
    logic        last_rw = 1'b0;
    logic [23:0] last_rgb = '0;
    logic [31:0] val_data = '0;

    // Event monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.oIF_ENA) begin
                ena_cnt   = ena_cnt + 1;
                last_addr = bus.oIF_ADDR;
                last_rw   = bus.oIF_RW;
                last_rgb  = {bus.oIF_R, bus.oIF_G, bus.oIF_B};
                if (bus.iIF_BUSY) ena_busy_cnt = ena_busy_cnt + 1;
                if (bus.oIF_RW && bus.oIF_ADDR < 23'd8) wr_cnt[bus.oIF_ADDR[2:0]] = wr_cnt[bus.oIF_ADDR[2:0]] + 1;
                if (bus.oIF_RW && {bus.oIF_R, bus.oIF_G, bus.oIF_B} == 24'hABCDEF) bad_color_cnt = bad_color_cnt + 1;
            end
            if (bus.oIF_FINISH) fin_cnt = fin_cnt + 1;
            if (bus.oBUS_VALID) begin
                val_cnt  = val_cnt + 1;
                val_data = bus.oBUS_DATA;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.iBUSMOD_REQ  = 1'b1;
        bus.iBUSMOD_ADDR = a;
        bus.iBUSMOD_DATA = d;
        @(posedge clk);
        #1;
        bus.iBUSMOD_REQ  = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.oIF_REQ) seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic grant();
        cycles(2);
        bus.iIF_ACK = 1'b1;
        cycles(1);
        bus.iIF_ACK = 1'b0;
    endtask

    task automatic wait_ena(input int base, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.oIF_ENA) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        int b_ena, b_fin, b_val, b_bad, b_busy;
        int b_wr [8];

        bus.iBUSMOD_REQ = 1'b0; bus.iBUSMOD_ADDR = '0; bus.iBUSMOD_DATA = '0;
        bus.iIF_ACK = 1'b0; bus.iIF_BREAK = 1'b0; bus.iIF_BUSY = 1'b0;
        bus.iIF_VALID = 1'b0; bus.iIF_DATA = '0;

        // Reset state
        cycles(3);
        check("rst_req", bus.oIF_REQ, 1'b0);
        check("rst_ena", bus.oIF_ENA, 1'b0);
        check("rst_wait", bus.oBUSMOD_WAIT, 1'b0);
        check("rst_valid", bus.oBUS_VALID, 1'b0);
        check("rst_finish", bus.oIF_FINISH, 1'b0);
        rst = 1'b0;
        cycles(2);

        // Single pixel write
        b_ena = ena_cnt; b_fin = fin_cnt;
        push(32'h0000_3105, 32'h0012_3456);
        wait_req(seen);
        check("wr_req_seen", seen, 1'b1);
        grant();
        cycles(10);
        check("wr_ena_count", ena_cnt - b_ena, 1);
        check("wr_rw", last_rw, 1'b1);
        check("wr_addr", last_addr, 23'd5);
        check("wr_rgb", last_rgb, 24'h123456);
        check("wr_finish", fin_cnt - b_fin, 1);

        // Pixel read with 3-cycle return latency
        b_ena = ena_cnt; b_fin = fin_cnt; b_val = val_cnt;
        push(32'h8000_3100, 32'h0000_0000);
        wait_req(seen);
        check("rd_req_seen", seen, 1'b1);
        grant();
        wait_ena(b_ena, seen);
        check("rd_ena_seen", seen, 1'b1);
        check("rd_rw", bus.oIF_RW, 1'b0);
        check("rd_addr", bus.oIF_ADDR, 23'd0);
        repeat (3) @(posedge clk);
        #1;
        bus.iIF_VALID = 1'b1; bus.iIF_DATA = 32'hCAFE_F00D;
        cycles(1);
        bus.iIF_VALID = 1'b0; bus.iIF_DATA = 32'h0000_0000;
        cycles(8);
        check("rd_valid_count", val_cnt - b_val, 1);
        check("rd_data", val_data, 32'hCAFE_F00D);
        check("rd_ena_count", ena_cnt - b_ena, 1);
        check("rd_finish", fin_cnt - b_fin, 1);

        // Clear with BUSY toggling
        b_ena = ena_cnt; b_fin = fin_cnt; b_busy = ena_busy_cnt;
        for (int k = 0; k < 8; k++) b_wr[k] = wr_cnt[k];
        push(32'h0000_3000, 32'h00A1_B2C3);
        wait_req(seen);
        check("clr_req_seen", seen, 1'b1);
        grant();
        for (int i = 0; i < 40; i++) begin
            bus.iIF_BUSY = (i % 3 == 0);
            cycles(1);
        end
        bus.iIF_BUSY = 1'b0;
        cycles(5);
        for (int k = 0; k < 8; k++) check($sformatf("clr_write_idx%0d", k), wr_cnt[k] - b_wr[k], 1);
        check("clr_ena_count", ena_cnt - b_ena, 8);
        check("clr_ena_while_busy", ena_busy_cnt - b_busy, 0);
        check("clr_rgb", last_rgb, 24'hA1B2C3);
        check("clr_finish", fin_cnt - b_fin, 1);

        // Clear interrupted by BREAK right after index 3, then resumed
        b_ena = ena_cnt; b_fin = fin_cnt;
        for (int k = 0; k < 8; k++) b_wr[k] = wr_cnt[k];
        push(32'h0000_3000, 32'h000F_1E2D);
        wait_req(seen);
        grant();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.oIF_ENA && bus.oIF_ADDR == 23'd2) seen = 1'b1;
        end
        check("brk_idx2_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        bus.iIF_BREAK = 1'b1;
        @(negedge clk);
        check("brk_last_ena", bus.oIF_ENA, 1'b1);
        check("brk_last_addr", bus.oIF_ADDR, 23'd3);
        @(posedge clk);
        #1;
        bus.iIF_BREAK = 1'b0;
        wait_req(seen);
        check("brk_req_again", seen, 1'b1);
        check("brk_finish", fin_cnt - b_fin, 1);
        check("brk_writes_before", ena_cnt - b_ena, 4);
        grant();
        cycles(15);
        for (int k = 0; k < 8; k++) check($sformatf("brk_write_idx%0d", k), wr_cnt[k] - b_wr[k], 1);
        check("brk_ena_total", ena_cnt - b_ena, 8);
        check("brk_finish_total", fin_cnt - b_fin, 2);

        // FIFO full: 17 pushes without grant
        b_ena = ena_cnt; b_fin = fin_cnt; b_bad = bad_color_cnt;
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                push(32'h0000_5000, 32'h0000_0000);
            end else if (i == 16) begin
                push(32'h0000_3100, 32'h00AB_CDEF);
            end else begin
                push(32'h0000_3100 + (i % 8), 32'h0000_0100 + i);
            end
            if (i == 14) check("full_wait_after15", bus.oBUSMOD_WAIT, 1'b0);
            if (i == 15) check("full_wait_after16", bus.oBUSMOD_WAIT, 1'b1);
        end
        check("full_wait_after17", bus.oBUSMOD_WAIT, 1'b1);
        check("full_no_ena_before_grant", ena_cnt - b_ena, 0);
        wait_req(seen);
        check("full_req_seen", seen, 1'b1);
        grant();
        cycles(30);
        check("full_ena_count", ena_cnt - b_ena, 15);
        check("full_dropped_color", bad_color_cnt - b_bad, 0);
        check("full_finish", fin_cnt - b_fin, 1);
        check("full_wait_drained", bus.oBUSMOD_WAIT, 1'b0);

        // Reset while a read is outstanding
        b_ena = ena_cnt; b_fin = fin_cnt; b_val = val_cnt;
        push(32'h8000_3101, 32'h0000_0000);
        wait_req(seen);
        grant();
        wait_ena(b_ena, seen);
        check("mrst_ena_seen", seen, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(6);
        check("mrst_no_finish", fin_cnt - b_fin, 0);
        check("mrst_no_valid", val_cnt - b_val, 0);
        check("mrst_req_low", bus.oIF_REQ, 1'b0);
        check("mrst_wait_low", bus.oBUSMOD_WAIT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
